// File: rtl/vehicle_status_monitor.sv
// rtl/vehicle_status_monitor.sv - qualified overheat, fuel and trip-distance status flags
module vehicle_status_monitor #(
    parameter int unsigned TEMP_W    = 8,
    parameter int unsigned TEMP_HOT  = 90,
    parameter int unsigned TEMP_COOL = 80,
    parameter int unsigned HOT_CNT   = 3,
    parameter int unsigned FUEL_W    = 8,
    parameter int unsigned DIST_W    = 16
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_sample,
    input  logic              refuel,
    input  logic [FUEL_W-1:0] refuel_level,
    input  logic              trip_start,
    input  logic [DIST_W-1:0] trip_dist,
    input  logic              keep_driving,
    output logic              cpu_overheated,
    output logic              gas_tank_empty,
    output logic              arrived,
    output logic [FUEL_W-1:0] fuel_level,
    output logic [DIST_W-1:0] dist_remaining
);

    // hot_cnt only ever holds 0..HOT_CNT-1: the sample that would reach HOT_CNT moves to HOT instead
    localparam int unsigned CNT_W = (HOT_CNT > 1) ? $clog2(HOT_CNT) : 1;
    localparam logic [CNT_W-1:0]  HOT_LAST = CNT_W'(HOT_CNT - 1);
    localparam logic [TEMP_W-1:0] HOT_TH   = TEMP_W'(TEMP_HOT);
    localparam logic [TEMP_W-1:0] COOL_TH  = TEMP_W'(TEMP_COOL);

    typedef enum logic {
        COOL = 1'b0,
        HOT  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hot_cnt;
    logic             trip_active;
    logic             fuel_avail;
    logic             dist_avail;

    assign fuel_avail     = (fuel_level != '0);
    assign dist_avail     = (dist_remaining != '0);
    assign gas_tank_empty = ~fuel_avail;
    assign arrived        = trip_active & ~dist_avail;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state          <= COOL;
            hot_cnt        <= '0;
            cpu_overheated <= 1'b0;
        end else begin
            case (state)
                COOL: begin
                    if (temp_valid) begin
                        if (temp_sample >= HOT_TH) begin
                            if (hot_cnt == HOT_LAST) begin
                                state          <= HOT;
                                hot_cnt        <= '0;
                                cpu_overheated <= 1'b1;
                            end else begin
                                hot_cnt <= hot_cnt + CNT_W'(1);
                            end
                        end else begin
                            hot_cnt <= '0;
                        end
                    end
                end
                HOT: begin
                    // Samples between the two thresholds hold the flag (hysteresis band)
                    if (temp_valid && (temp_sample <= COOL_TH)) begin
                        state          <= COOL;
                        hot_cnt        <= '0;
                        cpu_overheated <= 1'b0;
                    end
                end
                default: begin
                    state          <= COOL;
                    hot_cnt        <= '0;
                    cpu_overheated <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            fuel_level <= '0;
        end else if (refuel) begin
            fuel_level <= refuel_level;
        end else if (keep_driving && fuel_avail) begin
            fuel_level <= fuel_level - FUEL_W'(1);
        end
    end

    // Distance only advances while there was fuel before this edge
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            dist_remaining <= '0;
            trip_active    <= 1'b0;
        end else if (trip_start) begin
            dist_remaining <= trip_dist;
            trip_active    <= 1'b1;
        end else if (trip_active && keep_driving && dist_avail && fuel_avail) begin
            dist_remaining <= dist_remaining - DIST_W'(1);
        end
    end

endmodule
